// File: rtl/axil_wr_fifo.sv
// Purpose : AXI4-lite write-channel buffer ahead of the write broadcast stage (AW/W FIFOs, B slice).
// Latency : AW/W 1 cycle minimum (no bypass); B 1 cycle through a one-entry register slice.
// Backpr. : s_*ready drops when a FIFO is full; m_axil_bready drops while a B response waits upstream.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   s_axil_aw*/w*/b* - upstream AXI4-lite write channels (from the master)
//   m_axil_aw*/w*/b* - downstream AXI4-lite write channels (to the broadcast stage)
//   status_aw_level  - AW FIFO occupancy, 0..2^AW_DEPTH_LOG2
//   status_w_level   - W FIFO occupancy, 0..2^W_DEPTH_LOG2

// Purpose : generic valid/ready FIFO, register array of 2^DEPTH_LOG2 entries.
// Latency : 1 cycle, a word pushed in cycle N appears on the output in cycle N+1.
// Backpr. : in_rdy = !full; push and pop in one cycle both take effect.
module axil_wr_fifo_q #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [WIDTH-1:0]      in_dat,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [WIDTH-1:0]      out_dat,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // Outputs are masked during reset because the pointers only clear at the reset edge.
    assign in_rdy  = !full && !rst;
    assign out_vld = !empty && !rst;
    assign out_dat = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign level   = rst ? '0 : (wr_ptr - rd_ptr);

    assign push = in_vld && in_rdy;
    assign pop  = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset; push is already blocked during reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_dat;
    end
endmodule

module axil_wr_fifo #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int AW_DEPTH_LOG2 = 2,
    parameter int W_DEPTH_LOG2  = 2
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]   s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,

    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [STRB_WIDTH-1:0]   m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,

    output logic [AW_DEPTH_LOG2:0]  status_aw_level,
    output logic [W_DEPTH_LOG2:0]   status_w_level
);
    typedef struct packed {
        logic [2:0]            prot;
        logic [ADDR_WIDTH-1:0] addr;
    } aw_t;

    typedef struct packed {
        logic [STRB_WIDTH-1:0] strb;
        logic [DATA_WIDTH-1:0] data;
    } w_t;

    aw_t aw_in_dat;
    aw_t aw_out_dat;
    w_t  w_in_dat;
    w_t  w_out_dat;

    assign aw_in_dat = '{prot: s_axil_awprot, addr: s_axil_awaddr};
    assign w_in_dat  = '{strb: s_axil_wstrb,  data: s_axil_wdata};

    axil_wr_fifo_q #(
        .WIDTH      ($bits(aw_t)),
        .DEPTH_LOG2 (AW_DEPTH_LOG2)
    ) u_aw_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (s_axil_awvalid),
        .in_rdy  (s_axil_awready),
        .in_dat  (aw_in_dat),
        .out_vld (m_axil_awvalid),
        .out_rdy (m_axil_awready),
        .out_dat (aw_out_dat),
        .level   (status_aw_level)
    );

    axil_wr_fifo_q #(
        .WIDTH      ($bits(w_t)),
        .DEPTH_LOG2 (W_DEPTH_LOG2)
    ) u_w_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (s_axil_wvalid),
        .in_rdy  (s_axil_wready),
        .in_dat  (w_in_dat),
        .out_vld (m_axil_wvalid),
        .out_rdy (m_axil_wready),
        .out_dat (w_out_dat),
        .level   (status_w_level)
    );

    assign m_axil_awaddr = aw_out_dat.addr;
    assign m_axil_awprot = aw_out_dat.prot;
    assign m_axil_wdata  = w_out_dat.data;
    assign m_axil_wstrb  = w_out_dat.strb;

    // B slice: one register, refilled in the same cycle the upstream master takes it.
    logic       b_vld;
    logic [1:0] b_dat;

    // Held at 1 during reset so the broadcast stage can flush responses being discarded.
    assign m_axil_bready = rst || !b_vld || s_axil_bready;
    assign s_axil_bvalid = b_vld && !rst;
    assign s_axil_bresp  = b_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            b_vld <= 1'b0;
            b_dat <= 2'b00;
        end else if (m_axil_bvalid && m_axil_bready) begin
            b_vld <= 1'b1;
            b_dat <= m_axil_bresp;
        end else if (s_axil_bready) begin
            b_vld <= 1'b0;
        end
    end
endmodule
